// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit memory port between an instruction-fetch
// requester (I) and a data requester (D) using a three-state IDLE/WAIT/DONE FSM.
// Each transaction waits at most 256 cycles for mem_ready before it times out.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration when both sides
// request together. By default D has fixed priority over I.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    // instruction-fetch side
    input  logic        i_req,
    input  logic [31:2] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    // data side
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:2] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    // shared memory port
    output logic        mem_req,
    output logic [31:2] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,
    // status
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] TIMEOUT_LAST = 8'd255;

    logic [1:0]  state_reg;
    logic        owner_d_reg;   // 1 = D side owns the current transaction
    logic [7:0]  cnt_reg;
    logic [31:2] addr_reg;
    logic        wen_reg;
    logic [63:0] wdata_reg;
    logic [63:0] rdata_reg;
    logic        err_reg;
    logic        d_win;

`ifdef MEM_ARB_RR_EN
    logic        last_d_reg;    // 1 = D side got the most recent grant
`endif

    // Pick the winner among the requests present this cycle
    always_comb begin
`ifdef MEM_ARB_RR_EN
        // Under contention the side not granted last time wins
        d_win = d_req && (!i_req || !last_d_reg);
`else
        d_win = d_req;
`endif
    end

    // Transaction FSM: grant, wait for the memory (with timeout), then acknowledge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            owner_d_reg <= 1'b0;
            cnt_reg     <= 8'd0;
            addr_reg    <= '0;
            wen_reg     <= 1'b0;
            wdata_reg   <= 64'd0;
            rdata_reg   <= 64'd0;
            err_reg     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        state_reg   <= ST_WAIT;
                        cnt_reg     <= 8'd0;
                        owner_d_reg <= d_win;
`ifdef MEM_ARB_RR_EN
                        last_d_reg  <= d_win;
`endif
                        if (d_win) begin
                            addr_reg  <= d_addr;
                            wen_reg   <= d_wen;
                            wdata_reg <= d_wdata;
                        end else begin
                            // Fetches are always reads with zero write data
                            addr_reg  <= i_addr;
                            wen_reg   <= 1'b0;
                            wdata_reg <= 64'd0;
                        end
                    end
                end
                ST_WAIT: begin
                    // A completion on the last allowed cycle beats the timeout
                    if (mem_ready) begin
                        rdata_reg <= mem_rdata;
                        err_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        rdata_reg <= 64'd0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg   <= cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state, so none depend on inputs
    always_comb begin
        busy      = (state_reg != ST_IDLE);
        mem_req   = (state_reg == ST_WAIT);
        mem_addr  = addr_reg;
        mem_wen   = wen_reg;
        mem_wdata = wdata_reg;
        i_ack     = (state_reg == ST_DONE) && !owner_d_reg;
        d_ack     = (state_reg == ST_DONE) &&  owner_d_reg;
        err       = (state_reg == ST_DONE) &&  err_reg;
        i_rdata   = rdata_reg[31:0];
        d_rdata   = rdata_reg;
    end

endmodule
